// File: rtl/ysyx_22050078_sb_regfile_pkg.sv
// ysyx_22050078_sb_regfile_pkg: shared widths, indices and defaults for the scoreboarded register file
package ysyx_22050078_sb_regfile_pkg;
   localparam int CPU_WIDTH = 64;
   localparam int REG_COUNT = 32;
   localparam int REG_ADDRW = $clog2(REG_COUNT);
   localparam int A0_IDX = 10;
   localparam int PEND_W_DEF = 2;
endpackage

// File: rtl/ysyx_22050078_sb_counter.sv
// ysyx_22050078_sb_counter: saturating pending-write counter, clear wins, inc+dec together holds
module ysyx_22050078_sb_counter #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_dec,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt,
   output logic         o_full,
   output logic         o_nz
);
   assign o_full = &o_cnt;
   assign o_nz = |o_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_cnt <= '0;
      else if (i_clr) o_cnt <= '0;
      else if (i_inc && !i_dec && !o_full) o_cnt <= o_cnt + 1'b1;
      else if (i_dec && !i_inc && o_nz) o_cnt <= o_cnt - 1'b1;
endmodule

// File: rtl/ysyx_22050078_sb_regfile.sv
// ysyx_22050078_sb_regfile: register file with per-register pending-write scoreboard
// Define YSYX_22050078_REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module ysyx_22050078_sb_regfile
   import ysyx_22050078_sb_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = ysyx_22050078_sb_regfile_pkg::CPU_WIDTH,
   parameter int REG_COUNT = ysyx_22050078_sb_regfile_pkg::REG_COUNT,
   parameter int ADDR_WIDTH = $clog2(REG_COUNT),
   parameter int RD_PORTS = 2,
   parameter int PEND_W = ysyx_22050078_sb_regfile_pkg::PEND_W_DEF
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_issue_valid,
   input  logic [ADDR_WIDTH-1:0]          i_issue_rd,
   output logic                           o_issue_ready,
   input  logic                           i_wen,
   input  logic [ADDR_WIDTH-1:0]          i_waddr,
   input  logic [DATA_WIDTH-1:0]          i_wdata,
   input  logic                           i_flush,
   input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_rs_addr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] o_rs_data,
   output logic [RD_PORTS-1:0]            o_rs_busy,
   output logic                           o_a0zero
);
   logic [DATA_WIDTH-1:0] regs [1:REG_COUNT-1];
   logic [DATA_WIDTH-1:0] rf [REG_COUNT];
   logic [PEND_W-1:0] cnt [REG_COUNT];
   logic [REG_COUNT-1:0] full, nz;
   logic accept;
   assign o_issue_ready = (i_issue_rd == '0) || !full[i_issue_rd];
   assign accept = i_issue_valid && o_issue_ready && i_issue_rd != '0;
   assign o_a0zero = ~|rf[A0_IDX];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) for (int i = 1; i < REG_COUNT; i++) regs[i] <= '0;
      else if (i_wen && i_waddr != '0) regs[i_waddr] <= i_wdata;
   // x0 is modelled as a constant entry so index 0 needs no special casing downstream
   assign rf[0] = '0;
   assign cnt[0] = '0;
   assign full[0] = 1'b0;
   assign nz[0] = 1'b0;
   for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
      assign rf[g] = regs[g];
      ysyx_22050078_sb_counter #(.W(PEND_W)) u_cnt (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_inc  (accept && i_issue_rd == ADDR_WIDTH'(g)),
         .i_dec  (i_wen && i_waddr == ADDR_WIDTH'(g)),
         .i_clr  (i_flush),
         .o_cnt  (cnt[g]),
         .o_full (full[g]),
         .o_nz   (nz[g])
      );
   end
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      logic hit;
      assign a = i_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
      assign hit = i_wen && a != '0 && i_waddr == a;
`else
      assign hit = 1'b0;
`endif
      // a forwarded write retires one pending count, so busy only if more remain
      assign o_rs_data[k*DATA_WIDTH +: DATA_WIDTH] = hit ? i_wdata : rf[a];
      assign o_rs_busy[k] = hit ? (cnt[a] > PEND_W'(1)) : nz[a];
   end
endmodule
